// File: rtl/vrect_fill_pkg.sv
// rtl/vrect_fill_pkg.sv - shared video geometry constants and fill-engine state encoding
package vrect_fill_pkg;

  localparam int VID_XRES   = 640;
  localparam int VID_YRES   = 480;
  localparam int VID_STRIDE = VID_XRES;

  localparam int VID_XWIDTH = 10;
  localparam int VID_YWIDTH = 10;
  localparam int VID_AWIDTH = 19;
  localparam int VID_DWIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

endpackage

// File: rtl/vrect_fill_rect_clip.sv
// rtl/vrect_fill_rect_clip.sv - combinational clip of a fill rectangle to the framebuffer
module rect_clip
  import vrect_fill_pkg::*;
#(
  parameter int XWIDTH = VID_XWIDTH,
  parameter int YWIDTH = VID_YWIDTH,
  parameter int AWIDTH = VID_AWIDTH,
  parameter int XRES   = VID_XRES,
  parameter int YRES   = VID_YRES
) (
  input  logic [XWIDTH-1:0] x,
  input  logic [YWIDTH-1:0] y,
  input  logic [XWIDTH-1:0] w,
  input  logic [YWIDTH-1:0] h,
  output logic              empty,
  output logic [XWIDTH-1:0] wc,
  output logic [YWIDTH-1:0] hc,
  output logic [AWIDTH-1:0] startAddr
);

  logic [XWIDTH:0] xRem;
  logic [YWIDTH:0] yRem;

  // One extra bit so an out-of-range origin cannot alias into a small remainder.
  assign xRem = (XWIDTH+1)'(XRES) - {1'b0, x};
  assign yRem = (YWIDTH+1)'(YRES) - {1'b0, y};

  assign empty = ({1'b0, x} >= (XWIDTH+1)'(XRES)) ||
                 ({1'b0, y} >= (YWIDTH+1)'(YRES)) ||
                 (w == '0) || (h == '0);

  assign wc = ({1'b0, w} < xRem) ? w : xRem[XWIDTH-1:0];
  assign hc = ({1'b0, h} < yRem) ? h : yRem[YWIDTH-1:0];

  assign startAddr = AWIDTH'(y) * AWIDTH'(XRES) + AWIDTH'(x);

endmodule

// File: rtl/vrect_fill.sv
// rtl/vrect_fill.sv - rectangle fill engine issuing one MMU write per clipped pixel
module vrect_fill
  import vrect_fill_pkg::*;
#(
  parameter int XWIDTH = VID_XWIDTH,
  parameter int YWIDTH = VID_YWIDTH,
  parameter int AWIDTH = VID_AWIDTH,
  parameter int DWIDTH = VID_DWIDTH,
  parameter int XRES   = VID_XRES,
  parameter int YRES   = VID_YRES
) (
  input  logic              MemClk,
  input  logic              RstN,
  input  logic              CmdValid,
  output logic              CmdReady,
  input  logic [XWIDTH-1:0] CmdX,
  input  logic [YWIDTH-1:0] CmdY,
  input  logic [XWIDTH-1:0] CmdW,
  input  logic [YWIDTH-1:0] CmdH,
  input  logic [DWIDTH-1:0] CmdColor,
  input  logic              Abort,
  output logic [AWIDTH-1:0] WriteAddr,
  output logic [DWIDTH-1:0] WriteData,
  output logic              HasWriteData,
  input  logic              WriteDataRdy,
  output logic              Busy,
  output logic              Done
);

  logic [1:0]        state;
  logic [XWIDTH-1:0] latX, latW, wcReg, colCnt;
  logic [YWIDTH-1:0] latY, latH, rowCnt;
  logic [DWIDTH-1:0] colorReg;
  logic [AWIDTH-1:0] rowBase, curAddr;

  logic              clipEmpty;
  logic [XWIDTH-1:0] clipWc;
  logic [YWIDTH-1:0] clipHc;
  logic [AWIDTH-1:0] clipStart;

  rect_clip #(
    .XWIDTH(XWIDTH), .YWIDTH(YWIDTH), .AWIDTH(AWIDTH), .XRES(XRES), .YRES(YRES)
  ) uClip (
    .x(latX), .y(latY), .w(latW), .h(latH),
    .empty(clipEmpty), .wc(clipWc), .hc(clipHc), .startAddr(clipStart)
  );

  assign CmdReady     = (state == ST_IDLE);
  assign HasWriteData = (state == ST_RUN);
  assign Busy         = (state != ST_IDLE);
  assign WriteAddr    = curAddr;
  assign WriteData    = colorReg;

  always_ff @(posedge MemClk or negedge RstN) begin
    if (!RstN) begin
      state    <= ST_IDLE;
      latX     <= '0;
      latY     <= '0;
      latW     <= '0;
      latH     <= '0;
      colorReg <= '0;
      wcReg    <= '0;
      colCnt   <= '0;
      rowCnt   <= '0;
      rowBase  <= '0;
      curAddr  <= '0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (CmdValid) begin
            latX     <= CmdX;
            latY     <= CmdY;
            latW     <= CmdW;
            latH     <= CmdH;
            colorReg <= CmdColor;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (Abort) begin
            state <= ST_IDLE;
          end else if (clipEmpty) begin
            Done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            rowBase <= clipStart;
            curAddr <= clipStart;
            wcReg   <= clipWc;
            colCnt  <= clipWc - XWIDTH'(1);
            rowCnt  <= clipHc - YWIDTH'(1);
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A pixel acknowledged together with Abort is already consumed; nothing to undo.
          if (Abort) begin
            state <= ST_IDLE;
          end else if (WriteDataRdy) begin
            if (colCnt != '0) begin
              curAddr <= curAddr + AWIDTH'(1);
              colCnt  <= colCnt - XWIDTH'(1);
            end else if (rowCnt != '0) begin
              rowBase <= rowBase + AWIDTH'(XRES);
              curAddr <= rowBase + AWIDTH'(XRES);
              colCnt  <= wcReg - XWIDTH'(1);
              rowCnt  <= rowCnt - YWIDTH'(1);
            end else begin
              Done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vrect_fill.sv
// tb/tb_vrect_fill.sv - self-checking bench for vrect_fill against a pixel-list reference model
module tb_vrect_fill;

  localparam int XRES = 640;
  localparam int YRES = 480;

  logic        MemClk = 1'b0;
  logic        RstN;
  logic        CmdValid;
  logic        CmdReady;
  logic [9:0]  CmdX, CmdY, CmdW, CmdH;
  logic [7:0]  CmdColor;
  logic        Abort;
  logic [18:0] WriteAddr;
  logic [7:0]  WriteData;
  logic        HasWriteData;
  logic        WriteDataRdy;
  logic        Busy;
  logic        Done;

  vrect_fill dut (
    .MemClk(MemClk), .RstN(RstN),
    .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdX(CmdX), .CmdY(CmdY), .CmdW(CmdW), .CmdH(CmdH), .CmdColor(CmdColor),
    .Abort(Abort),
    .WriteAddr(WriteAddr), .WriteData(WriteData),
    .HasWriteData(HasWriteData), .WriteDataRdy(WriteDataRdy),
    .Busy(Busy), .Done(Done)
  );

  always #5 MemClk = ~MemClk;

  int cyc = 0;
  always @(posedge MemClk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  int gotAddr[$];
  int gotData[$];
  int expAddr[$];
  int doneCount, doneCyc, acceptCyc, firstHwdCyc, lastRdyCyc;
  int unstable, extraDone, extraHwd;
  bit hwdSeen, busyAtSetup, hwdAtSetup, readyAtDone, afterAbortHwd;

  // Reference: every framebuffer pixel inside the rectangle, row-major.
  function automatic void buildExp(input int x, input int y, input int w, input int h);
    expAddr.delete();
    for (int r = y; r < y + h; r++)
      for (int c = x; c < x + w; c++)
        if (r < YRES && c < XRES) expAddr.push_back(r * XRES + c);
  endfunction

  function automatic int addrMismatches();
    int m = 0;
    if (gotAddr.size() != expAddr.size()) return 1 + ((gotAddr.size() > expAddr.size()) ?
        gotAddr.size() - expAddr.size() : expAddr.size() - gotAddr.size());
    foreach (expAddr[i]) if (gotAddr[i] != expAddr[i]) m++;
    return m;
  endfunction

  function automatic int dataMismatches(input int col);
    int m = 0;
    foreach (gotData[i]) if (gotData[i] != col) m++;
    return m;
  endfunction

  task automatic runCmd(input int x, input int y, input int w, input int h,
                        input int col, input int gap, input int abortAt);
    int budget, waitCnt;
    bit fin, abortSent, prevHwd, prevRdy;
    logic [18:0] prevAddr;
    logic [7:0]  prevData;
    gotAddr.delete();
    gotData.delete();
    doneCount = 0; doneCyc = -1; firstHwdCyc = -1; lastRdyCyc = -1;
    unstable = 0; extraDone = 0; extraHwd = 0;
    hwdSeen = 0; readyAtDone = 0; afterAbortHwd = 1;
    @(negedge MemClk);
    CmdX = 10'(x); CmdY = 10'(y); CmdW = 10'(w); CmdH = 10'(h);
    CmdColor = 8'(col);
    CmdValid = 1'b1;
    budget = 0;
    while (!CmdReady && budget < 1000) begin
      @(negedge MemClk);
      budget++;
    end
    if (!CmdReady) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout CmdReady=%0b required 1", CmdReady);
      CmdValid = 1'b0;
      return;
    end
    acceptCyc = cyc;
    @(negedge MemClk);
    CmdValid = 1'b0;
    busyAtSetup = Busy;
    hwdAtSetup = HasWriteData;
    fin = 0; abortSent = 0; waitCnt = 0; budget = 0;
    prevHwd = 0; prevRdy = 0; prevAddr = '0; prevData = '0;
    while (!fin) begin
      WriteDataRdy = 1'b0;
      Abort = 1'b0;
      if (HasWriteData && prevHwd && !prevRdy && (WriteAddr !== prevAddr || WriteData !== prevData))
        unstable++;
      prevHwd = HasWriteData; prevAddr = WriteAddr; prevData = WriteData;
      if (Done) begin
        doneCount++;
        doneCyc = cyc;
        readyAtDone = CmdReady;
        fin = 1;
      end else if (abortSent) begin
        afterAbortHwd = HasWriteData;
        fin = 1;
      end else if (HasWriteData) begin
        if (!hwdSeen) firstHwdCyc = cyc;
        hwdSeen = 1;
        if (waitCnt >= gap) begin
          WriteDataRdy = 1'b1;
          gotAddr.push_back(int'(WriteAddr));
          gotData.push_back(int'(WriteData));
          lastRdyCyc = cyc;
          waitCnt = 0;
          if (abortAt > 0 && gotAddr.size() == abortAt) begin
            Abort = 1'b1;
            abortSent = 1;
          end
        end else begin
          waitCnt++;
        end
      end else if (!Busy) begin
        fin = 1;
      end
      prevRdy = WriteDataRdy;
      if (!fin) begin
        @(negedge MemClk);
        budget++;
        if (budget > 400000) begin
          checks++; errors++;
          $display("FAIL fill_timeout writes=%0d required completion", gotAddr.size());
          WriteDataRdy = 1'b0;
          Abort = 1'b0;
          fin = 1;
        end
      end
    end
    repeat (3) begin
      @(negedge MemClk);
      if (Done) extraDone++;
      if (HasWriteData) extraHwd++;
    end
  endtask

  task automatic test_reset();
    RstN = 1'b0;
    CmdValid = 1'b0; Abort = 1'b0; WriteDataRdy = 1'b0;
    CmdX = '0; CmdY = '0; CmdW = '0; CmdH = '0; CmdColor = '0;
    repeat (3) @(negedge MemClk);
    checks++; if (CmdReady !== 1'b1) begin errors++; $display("FAIL reset_cmdready got %0b required 1", CmdReady); end
    checks++; if (HasWriteData !== 1'b0) begin errors++; $display("FAIL reset_hwd got %0b required 0", HasWriteData); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b required 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b required 0", Done); end
    checks++; if (WriteAddr !== 19'd0) begin errors++; $display("FAIL reset_addr got %0d required 0", WriteAddr); end
    checks++; if (WriteData !== 8'd0) begin errors++; $display("FAIL reset_data got %0h required 0", WriteData); end
    RstN = 1'b1;
    @(negedge MemClk);
  endtask

  task automatic test_basic();
    buildExp(10, 5, 3, 2);
    runCmd(10, 5, 3, 2, 8'h2A, 3, 0);
    checks++; if (addrMismatches() != 0) begin errors++; $display("FAIL basic_addr got %0d writes required %0d (first %0d)", gotAddr.size(), expAddr.size(), gotAddr.size() ? gotAddr[0] : -1); end
    checks++; if (dataMismatches(8'h2A) != 0) begin errors++; $display("FAIL basic_data bad=%0d required 0", dataMismatches(8'h2A)); end
    checks++; if (doneCount + extraDone != 1) begin errors++; $display("FAIL basic_done_count got %0d required 1", doneCount + extraDone); end
    checks++; if (doneCyc != lastRdyCyc + 1) begin errors++; $display("FAIL basic_done_time got %0d required %0d", doneCyc, lastRdyCyc + 1); end
    checks++; if (!busyAtSetup || hwdAtSetup) begin errors++; $display("FAIL basic_setup busy=%0b hwd=%0b required 1/0", busyAtSetup, hwdAtSetup); end
    checks++; if (firstHwdCyc != acceptCyc + 2) begin errors++; $display("FAIL basic_hwd_latency got %0d required %0d", firstHwdCyc, acceptCyc + 2); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL basic_stable changes=%0d required 0", unstable); end
    checks++; if (readyAtDone !== 1'b1) begin errors++; $display("FAIL basic_ready_at_done got %0b required 1", readyAtDone); end
  endtask

  task automatic test_clip();
    buildExp(638, 479, 5, 3);
    runCmd(638, 479, 5, 3, 8'h5C, 1, 0);
    checks++; if (addrMismatches() != 0) begin errors++; $display("FAIL clip_addr got %0d writes required %0d", gotAddr.size(), expAddr.size()); end
    checks++; if (doneCount != 1 || extraDone != 0) begin errors++; $display("FAIL clip_done got %0d+%0d required 1", doneCount, extraDone); end
  endtask

  task automatic test_empty();
    int xs[2] = '{20, 640};
    int ws[2] = '{0, 4};
    for (int i = 0; i < 2; i++) begin
      runCmd(xs[i], 7, ws[i], 3, 8'h11, 0, 0);
      checks++; if (hwdSeen || extraHwd != 0) begin errors++; $display("FAIL empty%0d_hwd got asserted required none", i); end
      checks++; if (doneCyc != acceptCyc + 2) begin errors++; $display("FAIL empty%0d_done_time got %0d required %0d", i, doneCyc, acceptCyc + 2); end
      checks++; if (readyAtDone !== 1'b1 || !busyAtSetup) begin errors++; $display("FAIL empty%0d_handshake ready=%0b busy=%0b required 1/1", i, readyAtDone, busyAtSetup); end
    end
  endtask

  task automatic test_clear();
    buildExp(0, 0, 640, 40);
    runCmd(0, 0, 640, 40, 8'h00, 0, 0);
    checks++; if (addrMismatches() != 0) begin errors++; $display("FAIL clear_addr got %0d writes required %0d", gotAddr.size(), expAddr.size()); end
    checks++; if (doneCyc != lastRdyCyc + 1) begin errors++; $display("FAIL clear_done_time got %0d required %0d", doneCyc, lastRdyCyc + 1); end
    buildExp(0, 470, 640, 100);
    runCmd(0, 470, 640, 100, 8'hFF, 0, 0);
    checks++; if (addrMismatches() != 0 || gotAddr[$] != 307199) begin errors++; $display("FAIL clear_bottom got %0d writes required %0d ending 307199", gotAddr.size(), expAddr.size()); end
  endtask

  task automatic test_abort();
    buildExp(20, 30, 4, 4);
    runCmd(20, 30, 4, 4, 8'h77, 1, 3);
    checks++; if (gotAddr.size() != 3 || gotAddr[0] != expAddr[0] || gotAddr[2] != expAddr[2]) begin errors++; $display("FAIL abort_addr got %0d writes required 3 starting %0d", gotAddr.size(), expAddr[0]); end
    checks++; if (afterAbortHwd !== 1'b0 || extraHwd != 0) begin errors++; $display("FAIL abort_hwd got %0b required 0", afterAbortHwd); end
    checks++; if (doneCount + extraDone != 0) begin errors++; $display("FAIL abort_done got %0d required 0", doneCount + extraDone); end
    runCmd(0, 0, 1, 1, 8'h33, 0, 0);
    checks++; if (gotAddr.size() != 1 || gotAddr[0] != 0) begin errors++; $display("FAIL abort_next got %0d writes required 1 at 0", gotAddr.size()); end
    // Abort while idle must not disturb the next fill.
    @(negedge MemClk); Abort = 1'b1;
    @(negedge MemClk); Abort = 1'b0;
    checks++; if (Busy !== 1'b0 || CmdReady !== 1'b1) begin errors++; $display("FAIL abort_idle busy=%0b ready=%0b required 0/1", Busy, CmdReady); end
  endtask

  task automatic test_reset_midrun();
    int budget = 0;
    @(negedge MemClk);
    CmdX = 10'd100; CmdY = 10'd100; CmdW = 10'd5; CmdH = 10'd5; CmdColor = 8'h9E;
    CmdValid = 1'b1;
    @(negedge MemClk);
    CmdValid = 1'b0;
    while (!HasWriteData && budget < 20) begin @(negedge MemClk); budget++; end
    repeat (3) begin
      WriteDataRdy = 1'b1;
      @(negedge MemClk);
    end
    WriteDataRdy = 1'b0;
    checks++; if (HasWriteData !== 1'b1) begin errors++; $display("FAIL midrun_setup hwd=%0b required 1", HasWriteData); end
    #2 RstN = 1'b0;
    #1;
    checks++; if (HasWriteData !== 1'b0 || Busy !== 1'b0 || CmdReady !== 1'b1 || Done !== 1'b0)
      begin errors++; $display("FAIL midrun_reset_ctrl hwd=%0b busy=%0b ready=%0b done=%0b required 0/0/1/0", HasWriteData, Busy, CmdReady, Done); end
    checks++; if (WriteAddr !== 19'd0 || WriteData !== 8'd0) begin errors++; $display("FAIL midrun_reset_bus addr=%0d data=%0h required 0/0", WriteAddr, WriteData); end
    @(negedge MemClk);
    RstN = 1'b1;
    @(negedge MemClk);
    checks++; if (CmdReady !== 1'b1) begin errors++; $display("FAIL midrun_release ready=%0b required 1", CmdReady); end
    buildExp(3, 2, 2, 2);
    runCmd(3, 2, 2, 2, 8'h44, 0, 0);
    checks++; if (addrMismatches() != 0 || doneCount != 1) begin errors++; $display("FAIL midrun_next got %0d writes done=%0d required %0d/1", gotAddr.size(), doneCount, expAddr.size()); end
  endtask

  task automatic test_random();
    int x, y, w, h, col, gap, bad;
    for (int i = 0; i < 24; i++) begin
      x = (i % 3 == 0) ? $urandom_range(630, 645) : $urandom_range(0, 660);
      y = (i % 4 == 0) ? $urandom_range(474, 484) : $urandom_range(0, 490);
      w = $urandom_range(0, 12);
      h = $urandom_range(0, 6);
      col = $urandom_range(0, 255);
      gap = $urandom_range(0, 3);
      buildExp(x, y, w, h);
      runCmd(x, y, w, h, col, gap, 0);
      bad = addrMismatches() + dataMismatches(col);
      checks++; if (bad != 0) begin errors++; $display("FAIL rand%0d_pixels x=%0d y=%0d w=%0d h=%0d got %0d writes required %0d", i, x, y, w, h, gotAddr.size(), expAddr.size()); end
      checks++;
      if (doneCount != 1 || extraDone != 0 || unstable != 0 ||
          (expAddr.size() == 0 && doneCyc != acceptCyc + 2) ||
          (expAddr.size() != 0 && doneCyc != lastRdyCyc + 1)) begin
        errors++;
        $display("FAIL rand%0d_done done=%0d extra=%0d unstable=%0d at %0d required one pulse on time", i, doneCount, extraDone, unstable, doneCyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_empty();
    test_clear();
    test_abort();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
